// File: rtl/demux_pkg.sv
// Shared constants, channel index type and routing-mode enum for the
// 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int unsigned CH_NUM      = 4;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned DATA_W_DFLT = 16;
  localparam int unsigned CNT_W       = 16;

  typedef logic [SEL_W-1:0] ch_idx_t;

  typedef enum logic {
    ROUTE_SEL = 1'b0,
    ROUTE_RR  = 1'b1
  } route_mode_e;

  function automatic logic [CH_NUM-1:0] ch_onehot(input ch_idx_t idx);
    logic [CH_NUM-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/demux_ch_reg.sv
// One-entry valid/ready holding register for a single output channel.
// Data is held stable while valid and not ready; it keeps its last value after draining.
module demux_ch_reg
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              can_load
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // A load in the same cycle as a drain wins, keeping valid high for full rate.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end else if (valid_q && m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign m_data   = data_q;
  assign m_valid  = valid_q;
  assign can_load = ~valid_q | m_ready;

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demultiplexer: explicit-select or round-robin routing.
// Optional per-channel accept counters on output ch_cnt when DEMUX_1X4_CNT_EN is defined.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DFLT,
  parameter int unsigned CH_NUM = demux_pkg::CH_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic                     auto_en,
  output logic [CH_NUM*DATA_W-1:0] m_data,
  output logic [CH_NUM-1:0]        m_valid,
  input  logic [CH_NUM-1:0]        m_ready
`ifdef DEMUX_1X4_CNT_EN
  ,
  output logic [CH_NUM*CNT_W-1:0]  ch_cnt
`endif
);

  route_mode_e       mode;
  ch_idx_t           tgt;
  ch_idx_t           rr_ptr_q, rr_ptr_d;
  logic              accept;
  logic [CH_NUM-1:0] load;
  logic [CH_NUM-1:0] can_load;

  assign mode = route_mode_e'(auto_en);

  // Routing is decided only by the target channel's state, so a stalled
  // channel never blocks traffic aimed elsewhere.
  always_comb begin
    tgt      = (mode == ROUTE_RR) ? rr_ptr_q : s_sel;
    s_ready  = ~rst & can_load[tgt];
    accept   = s_valid & s_ready;
    load     = accept ? ch_onehot(tgt) : '0;
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode == ROUTE_RR)) begin
      rr_ptr_d = rr_ptr_q + ch_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    demux_ch_reg #(
      .DATA_W (DATA_W)
    ) u_ch_reg (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .data_in  (s_data),
      .m_data   (m_data[k*DATA_W +: DATA_W]),
      .m_valid  (m_valid[k]),
      .m_ready  (m_ready[k]),
      .can_load (can_load[k])
    );
  end

`ifdef DEMUX_1X4_CNT_EN
  logic [CH_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int unsigned k = 0; k < CH_NUM; k++) begin
      if (load[k]) begin
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ch_cnt = cnt_q;
`endif

endmodule

// File: doc/demux_1x4_stream.md
Name: demux_1x4_stream

Overview:
- Registered 1-to-4 stream demultiplexer, the distribution counterpart of the 4:1 select mux.
- Routes one input sample stream to one of four output channels, chosen either by an explicit select or by an internal round-robin pointer.
- Each channel has a one-entry output register with a valid/ready handshake.
- Sits between a single-rate DSP producer (e.g. filter output) and four parallel consumers (polyphase branches, per-lane processing).

Parameters:
- DATA_W, 16, sample width in bits
- CH_NUM, 4, number of output channels; fixed at 4, not to be overridden

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- s_data  input  DATA_W  input sample
- s_sel  input  2  target channel in select mode (0..3)
- s_valid  input  1  input sample valid
- s_ready  output  1  block can accept the sample this cycle
- auto_en  input  1  1 = round-robin routing, 0 = s_sel routing
- m_data  output  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- m_valid  output  4  per-channel output valid
- m_ready  input  4  per-channel consumer ready

Behaviour:
- Reset (rst=1 at a clk edge):
  - m_valid=4'b0000, m_data=0, rr_ptr=0.
  - Reset overrides any same-cycle transfer; pending data is discarded.
- Target channel, combinational: tgt = auto_en ? rr_ptr : s_sel.
- s_ready is combinational: s_ready = ~rst & (~m_valid[tgt] | m_ready[tgt]). It depends only on the target channel's state.
- Accept: s_valid & s_ready at the edge.
  - m_data[tgt] <= s_data and m_valid[tgt] <= 1.
  - Latency is 1 cycle, input to m_valid.
- Drain: m_valid[k] & m_ready[k] at the edge with no accept into k clears m_valid[k]. m_data[k] holds its last value.
- Drain and accept on the same channel in the same cycle: new data is loaded and m_valid[k] stays 1. Full throughput is one sample per cycle.
- Non-target channels drain independently in the same cycle as an accept elsewhere.
- Stall: when m_valid[tgt]=1 and m_ready[tgt]=0, s_ready=0. The producer must hold s_data and s_valid; no data is lost or duplicated.
- While m_valid[k]=1 and m_ready[k]=0, m_data[k] must stay stable.
- Round-robin pointer:
  - rr_ptr advances by 1 only on an accept while auto_en=1; wraps 3->0.
  - When auto_en=0, rr_ptr holds its value.
  - Toggling auto_en takes effect on tgt immediately (combinational); no pointer reset.
- s_sel is sampled only in the accept cycle. It may change freely when s_valid=0.
- No arithmetic on data; samples pass through bit-exact.

Optional Feature:
- Macro: DEMUX_1X4_CNT_EN.
- Defined:
  - Adds output port ch_cnt (4*16 bits): four 16-bit counters of accepted samples per channel.
  - Counters increment on accept into that channel and wrap at 0xFFFF->0.
  - rst clears them to 0.
  - They update in the same edge as the corresponding m_valid.
- Undefined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - CH_NUM=4
  - SEL_W=2
  - default DATA_W=16
  - CNT_W=16
  - typedef of the 2-bit channel index
- Sub-module demux_ch_reg: one-entry valid/ready holding register with load, data_in, m_data, m_valid, m_ready and a "can_load" output (~m_valid | m_ready).
  - Instantiated 4x; the top holds tgt decode, s_ready mux, rr_ptr and the optional counters.

Test Plan:
- Reset: drive rst=1 for 2 cycles with s_valid=1 -> m_valid=0000, m_data=0, s_ready=0. After release, a single sample 0x1234 with s_sel=2 -> m_valid=0100, m_data[2]=0x1234 one cycle later.
- Select mode at full rate: auto_en=0, m_ready=1111, send 0x0001..0x0004 with s_sel=0,1,2,3 back-to-back -> each appears on its channel 1 cycle later; s_ready held at 1 throughout.
- Round robin with wrap: auto_en=1, send 6 samples 0xA0..0xA5 -> channels 0,1,2,3,0,1 receive them in order; rr_ptr=2 at the end.
- Backpressure: auto_en=0, s_sel=1, m_ready[1]=0, send 0x55 then 0x66 -> 0x55 held on ch1 and s_ready=0 while 0x66 is presented. Raise m_ready[1] -> 0x66 loads the same cycle ch1 drains, with no gap in m_valid[1]. Meanwhile ch0 still accepts when s_sel is switched to 0.
- Mid-stream reset: ch0 and ch3 full and stalled, assert rst for 1 cycle -> m_valid=0000, rr_ptr=0. With DEMUX_1X4_CNT_EN, ch_cnt=0.
- Counters (macro defined): 65537 accepts into ch2 -> ch_cnt[2]=1 (wrapped), other counters 0.
